ucomb_ctrl: RTL
===============

UCOMB_CTRL -- requirements
Module: ucomb_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of cycles the applied frame is held before the ucomb outputs are sampled; legal range 1..15.
REQ-002 Port wb_clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-004 Port din, input, 1: serial frame data, LSB first.
REQ-005 Port din_valid, input, 1: din carries a valid bit this cycle.
REQ-006 Port din_ready, output, 1: block accepts din this cycle.
REQ-007 Ports u21_in [3:0], u31_in [5:0], u41_in [9:0], u22_in [5:0] and u22_sel [0], outputs: the applied frame, driven to the downstream ucomb.
REQ-008 Ports u21_out [0], u31_out [0], u41_out [0], u22_out [1:0] and mux_out [0], inputs: the responses returned from ucomb.
REQ-009 Port dout, output, 1: serial result data, LSB first.
REQ-010 Port dout_valid, output, 1: dout holds a valid result bit.
REQ-011 Port dout_ready, input, 1: consumer accepts dout this cycle.
REQ-012 Port busy, output, 1: high in every state except LOAD.

Function
REQ-013 Frame is 27 bits, with this layout:
  - [3:0] u21_in
  - [9:4] u31_in
  - [19:10] u41_in
  - [25:20] u22_in
  - [26] u22_sel
  - The first accepted bit becomes frame bit 0.
REQ-014 Result is 6 bits, with this layout:
  - [0] u21_out
  - [1] u31_out
  - [2] u41_out
  - [4:3] u22_out
  - [5] mux_out
REQ-015 The FSM has three states, LOAD, SETTLE and SHIFT, and enters LOAD on reset.
REQ-016 LOAD behaviour:
  - din_ready=1.
  - On din_valid&&din_ready, din goes into the shadow shift register and the bit counter increments.
  - The 27th accepted bit copies the complete shadow frame into the applied register at the same edge.
  - The bit counter clears to 0 and the FSM goes to SETTLE.
REQ-017 The applied register drives the ucomb input ports directly and changes only on the 27th-bit edge; it is glitch-free while the shadow register fills.
REQ-018 SETTLE behaviour:
  - din_ready=0.
  - The settle counter counts SETTLE_CYCLES cycles.
  - At the edge ending the last SETTLE cycle, the result register samples the ucomb outputs and the FSM goes to SHIFT.
  - Frame-to-result latency is exactly SETTLE_CYCLES+1 edges after the 27th-bit edge.
REQ-019 SHIFT behaviour:
  - dout_valid=1 and dout=result[0].
  - On dout_valid&&dout_ready, the result shifts right by one and the out counter increments.
  - On the 6th handshake the FSM returns to LOAD at that edge.
REQ-020 dout_valid and dout stay stable while dout_ready=0; stalling is unbounded.
REQ-021 din_valid outside LOAD is ignored: nothing is stored and no counter moves.
REQ-022 dout_ready outside SHIFT is ignored; dout_valid=0 and dout=0 outside SHIFT.
REQ-023 A partial frame (fewer than 27 bits) persists indefinitely across idle cycles; the applied register keeps the previous frame.
REQ-024 In the first LOAD cycle after SHIFT, the block accepts a bit, so back-to-back frames run with no dead cycle.

Reset
REQ-025 With wb_rst_i high at an edge, the following apply, all with priority over every other event, including a simultaneous 27th bit or 6th handshake:
  - FSM to LOAD.
  - All counters to 0.
  - Shadow, applied and result registers to 0.
REQ-026 Output values during and immediately after reset:
  - din_ready=1 from the first cycle after reset.
  - All ucomb input ports 0.
  - dout=0, dout_valid=0, busy=0.
REQ-027 Reset mid-frame, mid-settle or mid-shift discards all partial data; the next accepted bit is frame bit 0.

Structure
REQ-028 Shared package contents:
  - FRAME_W=27 and RES_W=6.
  - Field offset/width constants for each frame and result field.
  - State enum {LOAD, SETTLE, SHIFT}.
REQ-029 No sub-module: single module, one FSM, three counters (5-bit bit, 4-bit settle, 3-bit out). The ucomb instance is made by the parent, not inside this block.

Verification
REQ-030 Load with SETTLE_CYCLES=2:
  - Stimulus: stream frame 27'h5A5_A5A5 continuously.
  - Required: applied ports equal the fields of h5A5A5A5 only after bit 27, and are 0 before it.
  - Required: busy rises at the same edge.
  - Required: result is sampled exactly 3 edges after bit 27.
REQ-031 Result shift with backpressure:
  - Stimulus: stub ucomb outputs to 6'b101101; toggle dout_ready 1,0,1,0...
  - Required: dout sequence 1,0,1,1,0,1.
  - Required: dout is stable during stalls; LOAD is re-entered after the 6th handshake.
REQ-032 Gapped input:
  - Stimulus: din_valid with random gaps over 27 bits; din_valid held high during SETTLE and SHIFT.
  - Required: frame is identical to the gap-free case; extra bits are ignored.
REQ-033 Reset mid-operation:
  - Stimulus: assert wb_rst_i after 13 bits, then send a full frame 27'h7FF_FFFF.
  - Required: all outputs are 0 during reset.
  - Required: the new frame applies correctly with no residue from the aborted frame.
REQ-034 Back-to-back frames:
  - Stimulus: two frames, the second starting in the cycle after the 6th handshake.
  - Required: no dead cycle; the second result is correct.
REQ-035 Reset collision:
  - Stimulus: assert wb_rst_i on the same edge as the 27th bit.
  - Required: the applied register stays 0 and the FSM is in LOAD.

Source files
------------

// File: rtl/ucomb_ctrl_pkg.sv
// Shared constants and types for the ucomb frame controller: frame/result
// field layout and the controller state encoding.
package ucomb_ctrl_pkg;

    localparam int unsigned FRAME_W = 27;
    localparam int unsigned RES_W   = 6;

    // Frame fields, LSB of the serial stream lands in bit 0
    localparam int unsigned U21_IN_OFF  = 0;
    localparam int unsigned U21_IN_W    = 4;
    localparam int unsigned U31_IN_OFF  = 4;
    localparam int unsigned U31_IN_W    = 6;
    localparam int unsigned U41_IN_OFF  = 10;
    localparam int unsigned U41_IN_W    = 10;
    localparam int unsigned U22_IN_OFF  = 20;
    localparam int unsigned U22_IN_W    = 6;
    localparam int unsigned U22_SEL_OFF = 26;

    localparam int unsigned U21_OUT_OFF = 0;
    localparam int unsigned U31_OUT_OFF = 1;
    localparam int unsigned U41_OUT_OFF = 2;
    localparam int unsigned U22_OUT_OFF = 3;
    localparam int unsigned U22_OUT_W   = 2;
    localparam int unsigned MUX_OUT_OFF = 5;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        SHIFT  = 2'd2
    } state_e;

endpackage

// File: rtl/ucomb_ctrl.sv
// Serial-in / serial-out wrapper around a combinational ucomb block: shifts a
// frame in, applies it atomically, waits for settling, then shifts the result out.
module ucomb_ctrl
    import ucomb_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [3:0] u21_in,
    output logic [5:0] u31_in,
    output logic [9:0] u41_in,
    output logic [5:0] u22_in,
    output logic       u22_sel,
    input  logic       u21_out,
    input  logic       u31_out,
    input  logic       u41_out,
    input  logic [1:0] u22_out,
    input  logic       mux_out,
    output logic       dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy
);

    state_e               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           settle_cnt_q, settle_cnt_d;
    logic [2:0]           out_cnt_q, out_cnt_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic [FRAME_W-1:0]   applied_q, applied_d;
    logic [RES_W-1:0]     result_q, result_d;
    logic [RES_W-1:0]     ucomb_res;

    always_comb begin
        ucomb_res                                   = '0;
        ucomb_res[U21_OUT_OFF]                      = u21_out;
        ucomb_res[U31_OUT_OFF]                      = u31_out;
        ucomb_res[U41_OUT_OFF]                      = u41_out;
        ucomb_res[U22_OUT_OFF +: U22_OUT_W]         = u22_out;
        ucomb_res[MUX_OUT_OFF]                      = mux_out;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= LOAD;
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            out_cnt_q    <= '0;
            shadow_q     <= '0;
            applied_q    <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            out_cnt_q    <= out_cnt_d;
            shadow_q     <= shadow_d;
            applied_q    <= applied_d;
            result_q     <= result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        settle_cnt_d = settle_cnt_q;
        out_cnt_d    = out_cnt_q;
        shadow_d     = shadow_q;
        applied_d    = applied_q;
        result_d     = result_q;
        din_ready    = 1'b0;
        dout_valid   = 1'b0;
        dout         = 1'b0;
        unique case (state_q)
            LOAD: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    shadow_d = {din, shadow_q[FRAME_W-1:1]};
                    if (bit_cnt_q == 5'(FRAME_W - 1)) begin
                        applied_d    = shadow_d;
                        bit_cnt_d    = '0;
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            SETTLE: begin
                // First SETTLE cycle is the one the new frame appears in; sample
                // after SETTLE_CYCLES further cycles of stable inputs.
                if (settle_cnt_q == 4'(SETTLE_CYCLES)) begin
                    result_d     = ucomb_res;
                    settle_cnt_d = '0;
                    state_d      = SHIFT;
                end else begin
                    settle_cnt_d = settle_cnt_q + 4'd1;
                end
            end
            SHIFT: begin
                dout_valid = 1'b1;
                dout       = result_q[0];
                if (dout_ready) begin
                    result_d = result_q >> 1;
                    if (out_cnt_q == 3'(RES_W - 1)) begin
                        out_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        out_cnt_d = out_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign busy    = (state_q != LOAD);
    assign u21_in  = applied_q[U21_IN_OFF +: U21_IN_W];
    assign u31_in  = applied_q[U31_IN_OFF +: U31_IN_W];
    assign u41_in  = applied_q[U41_IN_OFF +: U41_IN_W];
    assign u22_in  = applied_q[U22_IN_OFF +: U22_IN_W];
    assign u22_sel = applied_q[U22_SEL_OFF];

endmodule
